// File: rtl/ext_uart_rx.sv
// 8N1 UART receiver feeding the pico core's ext_data_i / ext_int_i pair.
// Latency: about 2 + HALF + (N+1)*CLKS_PER_BIT cycles from start edge to ext_int_o rise.
// Backpressure: none; the serial line cannot be stalled, ext_int_o is a fixed-width strobe.
module ext_uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int N            = 8,
   parameter int INT_CYCLES   = 2
) (
   input  logic         clk_i,
   input  logic         n_rst_i,
   input  logic         rx_i,
   output logic [N-1:0] ext_data_o,
   output logic         ext_int_o,
   output logic         frame_err_o,
   output logic         busy_o
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int BW   = (N > 1) ? $clog2(N) : 1;
   localparam int IW   = $clog2(INT_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [IW-1:0] INT_LOAD  = IW'(INT_CYCLES);
   localparam logic [IW-1:0] INT_ONE   = IW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          w_rxs;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [BW-1:0] r_bit_idx;
   logic [N-1:0]  r_shift;
   logic [N-1:0]  r_data;
   logic [IW-1:0] r_int_cnt;
   logic          r_frame_err;

   state_t        w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [BW-1:0] w_bit_idx_nxt;
   logic [N-1:0]  w_shift_nxt;
   logic [N-1:0]  w_data_nxt;
   logic [IW-1:0] w_int_cnt_nxt;
   logic          w_frame_err_nxt;

   // Two-flop synchronizer; resets to 1 so the line reads idle out of reset.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx_i;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rxs = r_sync2;

   // Receiver state, counters, shift register and output registers.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_int_cnt   <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_shift     <= w_shift_nxt;
         r_data      <= w_data_nxt;
         r_int_cnt   <= w_int_cnt_nxt;
         r_frame_err <= w_frame_err_nxt;
      end
   end

   // Next-state logic: half-bit start qualification, mid-bit data sampling, stop check.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_bit_idx_nxt   = r_bit_idx;
      w_shift_nxt     = r_shift;
      w_data_nxt      = r_data;
      w_int_cnt_nxt   = (r_int_cnt != '0) ? (r_int_cnt - INT_ONE) : r_int_cnt;
      w_frame_err_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = ST_START;
               w_cnt_nxt   = '0;
            end
         end
         ST_START: begin
            if (r_cnt == HALF_LAST) begin
               if (w_rxs) begin
                  // Start bit gone by mid-bit: treat as a glitch.
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt   = ST_DATA;
                  w_cnt_nxt     = '0;
                  w_bit_idx_nxt = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (r_cnt == CNT_LAST) begin
               w_shift_nxt = {w_rxs, r_shift[N-1:1]};
               w_cnt_nxt   = '0;
               if (r_bit_idx == BIT_LAST) begin
                  w_state_nxt = ST_STOP;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + BIT_ONE;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt = '0;
               if (w_rxs) begin
                  w_data_nxt    = r_shift;
                  w_int_cnt_nxt = INT_LOAD;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_frame_err_nxt = 1'b1;
                  w_state_nxt     = ST_BREAK;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         ST_BREAK: begin
            // Hold here until the line recovers so a stuck-low line reports once.
            if (w_rxs) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign ext_data_o  = r_data;
   assign ext_int_o   = (r_int_cnt != '0);
   assign frame_err_o = r_frame_err;
   assign busy_o      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ext_uart_rx.sv
// Bench for ext_uart_rx: directed scenarios plus random 8N1 frames.
// Expected bytes are queued as frames are sent; a monitor pops them on ext_int_o rising.
module tb_ext_uart_rx;

   localparam int CPB     = 16;
   localparam int INT_CYC = 2;
   localparam int LAT_MIN = 153;
   localparam int LAT_MAX = 155;

   logic       clk   = 1'b0;
   logic       n_rst = 1'b1;
   logic       rx    = 1'b1;
   logic [7:0] ext_data;
   logic       ext_int;
   logic       frame_err;
   logic       busy;

   int         checks      = 0;
   int         failures    = 0;
   int         cyc         = 0;
   int         err_pending = 0;
   logic [7:0] model_data  = 8'h00;
   logic [7:0] exp_q[$];
   int         start_q[$];

   logic       prev_int = 1'b0;
   logic       prev_err = 1'b0;
   int         int_w    = 0;

   ext_uart_rx #(
      .CLKS_PER_BIT(CPB),
      .N           (8),
      .INT_CYCLES  (INT_CYC)
   ) dut (
      .clk_i      (clk),
      .n_rst_i    (n_rst),
      .rx_i       (rx),
      .ext_data_o (ext_data),
      .ext_int_o  (ext_int),
      .frame_err_o(frame_err),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference model: a frame with a high stop bit yields its byte; a low stop bit yields one error.
   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      logic [9:0] bits;
      bits = {stop_ok, d, 1'b0};
      if (stop_ok) begin
         exp_q.push_back(d);
         start_q.push_back(cyc);
      end else begin
         err_pending++;
      end
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         if (i == 2) chk("busy_mid_frame", int'(busy), 1);
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || err_pending != 0 || ext_int || busy) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", int'(t < 500), 1);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_data"}, int'(ext_data), int'(model_data));
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_int"}, int'(ext_int), 0);
      chk({name, "_ferr"}, int'(frame_err), 0);
   endtask

   // Monitor: pops expected bytes on each ext_int_o rise, checks width, latency and errors.
   initial begin
      logic [7:0] e;
      int         st;
      int         lat;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            prev_int = 1'b0;
            prev_err = 1'b0;
            int_w    = 0;
         end else begin
            if (ext_int && !prev_int) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_int: ext_int rose with data 0x%0h, no byte expected", ext_data);
               end else begin
                  e  = exp_q.pop_front();
                  st = start_q.pop_front();
                  chk("rx_byte", int'(ext_data), int'(e));
                  model_data = e;
                  lat = cyc - st;
                  checks++;
                  if (lat < LAT_MIN || lat > LAT_MAX) begin
                     failures++;
                     $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                  end
               end
               int_w = 1;
            end else if (ext_int) begin
               int_w++;
               chk("data_stable", int'(ext_data), int'(model_data));
            end else if (prev_int) begin
               chk("int_width", int_w, INT_CYC);
            end
            if (frame_err) begin
               checks++;
               if (err_pending == 0) begin
                  failures++;
                  $display("FAIL unexpected_frame_err: got pulse expected none");
               end else begin
                  err_pending--;
               end
               if (prev_err) begin
                  failures++;
                  $display("FAIL frame_err_width: got >1 cycle expected 1");
               end
            end
            prev_int = ext_int;
            prev_err = frame_err;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic       saw;
      logic [7:0] d;
      logic       ok;
      logic [7:0] last_good;
      logic [7:0] b55;

      // Reset state
      #2;
      n_rst = 1'b0;
      #1;
      chk("rst_data", int'(ext_data), 0);
      chk("rst_int", int'(ext_int), 0);
      chk("rst_ferr", int'(frame_err), 0);
      chk("rst_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      n_rst = 1'b1;

      // Idle line for 100 cycles
      idle(100);
      chk_quiet("idle100");

      // Single byte 0xA5
      send_frame(8'hA5, 1'b1);
      idle(4);
      wait_drain();
      chk("a5_data", int'(ext_data), 8'hA5);

      // Back-to-back 0x3C, 0xFF with no idle gap
      send_frame(8'h3C, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(2);
      wait_drain();
      chk("b2b_data", int'(ext_data), 8'hFF);

      // 4-cycle low glitch
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) saw = 1'b1;
      end
      chk("glitch_busy_seen", int'(saw), 1);
      chk_quiet("glitch");

      // Bad stop bit then held-low line, then recovery with 0x42
      send_frame(8'h81, 1'b0);
      rx = 1'b0;
      repeat (200) @(negedge clk);
      chk("break_busy", int'(busy), 1);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      chk("break_err_count", err_pending, 0);
      chk_quiet("break");
      send_frame(8'h42, 1'b1);
      idle(4);
      wait_drain();
      chk("after_break_data", int'(ext_data), 8'h42);

      // Reset during bit 4 of 0x55
      b55 = 8'h55;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b55[i];
         repeat (CPB) @(negedge clk);
      end
      rx = b55[4];
      repeat (CPB / 2) @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("midrst_data", int'(ext_data), 0);
      chk("midrst_int", int'(ext_int), 0);
      chk("midrst_busy", int'(busy), 0);
      model_data = 8'h00;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      n_rst = 1'b1;
      idle(20);
      chk_quiet("post_rst");
      send_frame(8'h12, 1'b1);
      idle(4);
      wait_drain();
      chk("after_rst_data", int'(ext_data), 8'h12);

      // Random frames, occasionally with a bad stop bit
      last_good = 8'h12;
      for (int n = 0; n < 12; n++) begin
         d  = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
         send_frame(d, ok);
         if (ok) begin
            last_good = d;
            idle($urandom_range(0, 20));
         end else begin
            rx = 1'b0;
            repeat ($urandom_range(0, 40)) @(negedge clk);
            idle(4 + $urandom_range(0, 10));
         end
      end
      idle(4);
      wait_drain();
      chk("random_last_data", int'(ext_data), int'(last_good));
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
